// File: rtl/fp_seg_display_pkg.sv
// Shared constants and types for the floating-point 7-segment display slice.
package fp_seg_display_pkg;

   localparam int unsigned REFRESH_DIV_DEF = 100000;

   // Active-low segment codes, bit 0 = a ... bit 6 = g
   localparam logic [6:0] SEG_0     = 7'b1000000;
   localparam logic [6:0] SEG_1     = 7'b1111001;
   localparam logic [6:0] SEG_2     = 7'b0100100;
   localparam logic [6:0] SEG_3     = 7'b0110000;
   localparam logic [6:0] SEG_4     = 7'b0011001;
   localparam logic [6:0] SEG_5     = 7'b0010010;
   localparam logic [6:0] SEG_6     = 7'b0000010;
   localparam logic [6:0] SEG_7     = 7'b1111000;
   localparam logic [6:0] SEG_8     = 7'b0000000;
   localparam logic [6:0] SEG_9     = 7'b0010000;
   localparam logic [6:0] SEG_BLANK = 7'b1111111;
   localparam logic [6:0] SEG_MINUS = 7'b0111111;

   // Decoder codes above 9 carry the non-numeric glyphs
   localparam logic [3:0] CODE_MINUS = 4'hE;
   localparam logic [3:0] CODE_BLANK = 4'hF;

   typedef enum logic [1:0] {
      DIG0 = 2'd0,
      DIG1 = 2'd1,
      DIG2 = 2'd2,
      DIG3 = 2'd3
   } dig_idx_e;

   typedef struct packed {
      logic       s;
      logic [2:0] e;
      logic [3:0] f;
   } fp_val_t;

endpackage

// File: rtl/seg7_dec.sv
// Combinational 4-bit code to active-low 7-segment decoder (digits, minus, blank).
module seg7_dec
   import fp_seg_display_pkg::*;
(
   input  logic [3:0] val_i,
   output logic [6:0] seg_c
);

   always_comb begin
      seg_c = SEG_BLANK;
      case (val_i)
         4'd0:       seg_c = SEG_0;
         4'd1:       seg_c = SEG_1;
         4'd2:       seg_c = SEG_2;
         4'd3:       seg_c = SEG_3;
         4'd4:       seg_c = SEG_4;
         4'd5:       seg_c = SEG_5;
         4'd6:       seg_c = SEG_6;
         4'd7:       seg_c = SEG_7;
         4'd8:       seg_c = SEG_8;
         4'd9:       seg_c = SEG_9;
         CODE_MINUS: seg_c = SEG_MINUS;
         default:    seg_c = SEG_BLANK;
      endcase
   end

endmodule

// File: rtl/fp_seg_display.sv
// Multiplexed 4-digit display of a latched {S,E,F} value: [sign][E].[F tens][F ones].
module fp_seg_display
   import fp_seg_display_pkg::*;
#(
   parameter int unsigned REFRESH_DIV = REFRESH_DIV_DEF
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       load,
   input  logic       S,
   input  logic [2:0] E,
   input  logic [3:0] F,
   output logic [6:0] seg,
   output logic       dp,
   output logic [3:0] an
);

   localparam int unsigned CNT_W = $clog2(REFRESH_DIV);
   localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(REFRESH_DIV - 1);

   fp_val_t          val_q, val_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   dig_idx_e         idx_q, idx_d;
   logic             wrap_c;
   logic [3:0]       code_c;
   logic [6:0]       seg_dec_c;
   logic [6:0]       seg_q;
   logic             dp_q, dp_d;
   logic [3:0]       an_q, an_d;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         val_q <= '0;
         cnt_q <= '0;
         idx_q <= DIG0;
         seg_q <= SEG_BLANK;
         dp_q  <= 1'b1;
         an_q  <= 4'b1111;
      end else begin
         val_q <= val_d;
         cnt_q <= cnt_d;
         idx_q <= idx_d;
         seg_q <= seg_dec_c;
         dp_q  <= dp_d;
         an_q  <= an_d;
      end
   end

   // Value capture, free-running refresh counter and scan advance on wrap
   always_comb begin
      val_d  = val_q;
      cnt_d  = cnt_q + CNT_W'(1);
      idx_d  = idx_q;
      wrap_c = (cnt_q == CNT_MAX);
      if (load) begin
         val_d = '{s: S, e: E, f: F};
      end
      if (wrap_c) begin
         cnt_d = '0;
         case (idx_q)
            DIG0:    idx_d = DIG1;
            DIG1:    idx_d = DIG2;
            DIG2:    idx_d = DIG3;
            default: idx_d = DIG0;
         endcase
      end
   end

   // Content, enable and decimal point of the currently selected digit
   always_comb begin
      code_c = CODE_BLANK;
      dp_d   = 1'b1;
      an_d   = 4'b1111;
      case (idx_q)
         DIG0: begin
            an_d   = 4'b1110;
            code_c = (val_q.f >= 4'd10) ? 4'(val_q.f - 4'd10) : val_q.f;
         end
         DIG1: begin
            an_d   = 4'b1101;
            code_c = (val_q.f >= 4'd10) ? 4'd1 : CODE_BLANK;
         end
         DIG2: begin
            an_d   = 4'b1011;
            dp_d   = 1'b0;
            code_c = {1'b0, val_q.e};
         end
         default: begin
            an_d   = 4'b0111;
            code_c = val_q.s ? CODE_MINUS : CODE_BLANK;
         end
      endcase
   end

   seg7_dec u_dec (
      .val_i (code_c),
      .seg_c (seg_dec_c)
   );

   assign seg = seg_q;
   assign dp  = dp_q;
   assign an  = an_q;

endmodule

// File: tb/tb_fp_seg_display.sv
// Directed bench for fp_seg_display with a 4-cycle refresh period.
module tb_fp_seg_display;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       load;
   logic       S;
   logic [2:0] E;
   logic [3:0] F;
   logic [6:0] seg;
   logic       dp;
   logic [3:0] an;

   int n_chk = 0;
   int n_err = 0;
   int cyc   = 0;

   localparam logic [6:0] T [10] = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
                                     7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
                                     7'b0000000, 7'b0010000};
   localparam logic [6:0] BL = 7'b1111111;
   localparam logic [6:0] MI = 7'b0111111;

   always #5 clk = ~clk;

   fp_seg_display #(.REFRESH_DIV(4)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .load  (load),
      .S     (S),
      .E     (E),
      .F     (F),
      .seg   (seg),
      .dp    (dp),
      .an    (an)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(negedge clk);
      cyc++;
   endtask

   // Digit shown after edge c (c counted from reset release, first edge = 1)
   function automatic int dig_of(input int c);
      return ((c - 1) / 4) % 4;
   endfunction

   function automatic logic [3:0] an_of(input int d);
      logic [3:0] a;
      a    = 4'b1111;
      a[d] = 1'b0;
      return a;
   endfunction

   function automatic logic [6:0] content(input int d, input logic s, input logic [2:0] e,
                                          input logic [3:0] f);
      case (d)
         3:       return s ? MI : BL;
         2:       return T[e];
         1:       return (f >= 4'd10) ? T[1] : BL;
         default: return T[int'(f) % 10];
      endcase
   endfunction

   task automatic check_scan(input logic [6:0] t3, input logic [6:0] t2, input logic [6:0] t1,
                             input logic [6:0] t0, input int n, input bit wiggle);
      logic [6:0] t [4];
      int d;
      t[0] = t0; t[1] = t1; t[2] = t2; t[3] = t3;
      for (int i = 0; i < n; i++) begin
         if (wiggle) begin
            S = 1'($urandom);
            E = 3'($urandom);
            F = 4'($urandom);
         end
         tick();
         d = dig_of(cyc);
         chk($sformatf("an c%0d", cyc), 32'(an), 32'(an_of(d)));
         chk($sformatf("seg c%0d d%0d", cyc, d), 32'(seg), 32'(t[d]));
         chk($sformatf("dp c%0d", cyc), 32'(dp), 32'(d != 2));
      end
   endtask

   initial begin
      logic       ps, vs;
      logic [2:0] pe, ve;
      logic [3:0] pf, vf;
      int         d;
      int         guard;

      rst_n = 1'b0; load = 1'b0; S = 1'b0; E = 3'd0; F = 4'd0;
      tick();
      tick();
      chk("rst an", 32'(an), 32'hF);
      chk("rst seg", 32'(seg), 32'(BL));
      chk("rst dp", 32'(dp), 32'd1);

      // Idle scan with zero value
      rst_n = 1'b1;
      cyc   = 0;
      check_scan(BL, T[0], BL, T[0], 16, 1'b0);

      // S=0 E=7 F=15; capture edge still shows the old digit
      load = 1'b1; S = 1'b0; E = 3'd7; F = 4'd15;
      tick();
      load = 1'b0;
      chk("lat1 old", 32'(seg), 32'(T[0]));
      check_scan(BL, T[7], T[1], T[5], 16, 1'b0);

      // S=1 E=0 F=1
      load = 1'b1; S = 1'b1; E = 3'd0; F = 4'd1;
      tick();
      load = 1'b0;
      chk("lat2 old", 32'(seg), 32'(T[5]));
      check_scan(MI, T[0], BL, T[1], 16, 1'b0);

      // Load coincident with counter wrap (edge index multiple of 4)
      check_scan(MI, T[0], BL, T[1], 1, 1'b0);
      chk("wrap align", 32'(cyc % 4), 32'd3);
      load = 1'b1; S = 1'b0; E = 3'd5; F = 4'd12;
      tick();
      load = 1'b0;
      chk("wrap an", 32'(an), 32'(4'b1110));
      chk("wrap seg old", 32'(seg), 32'(T[1]));
      check_scan(BL, T[5], T[1], T[2], 16, 1'b0);

      // Inputs move with load low: display unchanged
      check_scan(BL, T[5], T[1], T[2], 16, 1'b1);

      // Continuous load tracks inputs with one-edge latency
      load = 1'b1;
      vs = 1'b1; ve = 3'd3; vf = 4'd9;
      S = vs; E = ve; F = vf;
      tick();
      for (int i = 0; i < 12; i++) begin
         ps = vs; pe = ve; pf = vf;
         vs = 1'($urandom); ve = 3'($urandom); vf = 4'($urandom);
         S = vs; E = ve; F = vf;
         tick();
         d = dig_of(cyc);
         chk($sformatf("trk an c%0d", cyc), 32'(an), 32'(an_of(d)));
         chk($sformatf("trk seg c%0d", cyc), 32'(seg), 32'(content(d, ps, pe, pf)));
      end
      load = 1'b0;
      tick();
      d = dig_of(cyc);
      chk("trk last", 32'(seg), 32'(content(d, vs, ve, vf)));

      // Asynchronous reset while DIG2 is enabled
      guard = 0;
      while (dig_of(cyc) != 2 && guard < 16) begin
         tick();
         guard++;
      end
      chk("mid an dig2", 32'(an), 32'(4'b1011));
      rst_n = 1'b0;
      #1;
      chk("async an", 32'(an), 32'hF);
      chk("async seg", 32'(seg), 32'(BL));
      chk("async dp", 32'(dp), 32'd1);
      tick();
      chk("hold an", 32'(an), 32'hF);
      rst_n = 1'b1;
      cyc   = 0;
      check_scan(BL, T[0], BL, T[0], 16, 1'b0);

      $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
      $finish;
   end

endmodule

// File: doc/fp_seg_display.md
FP_SEG_DISPLAY -- requirements
Module: fp_seg_display

Interface
REQ-001 Parameter REFRESH_DIV, default 100000, means the number of clock cycles each digit stays enabled (minimum 2).
REQ-002 The block SHALL have one clock and an asynchronous, active-low reset.
REQ-003 Port `clk`, input, 1 bit: the system clock; all state updates on its rising edge.
REQ-004 Port `rst_n`, input, 1 bit: asynchronous active-low reset.
REQ-005 Port `load`, input, 1 bit: when high at a rising edge, capture S/E/F.
REQ-006 Port `S`, input, 1 bit: sign from the FP converter; 1 means negative.
REQ-007 Port `E`, input, 3 bits: exponent from the FP converter, range 0..7.
REQ-008 Port `F`, input, 4 bits: significand from the FP converter, range 0..15.
REQ-009 Port `seg`, output, 7 bits: active-low segments with seg[0]=a … seg[6]=g.
REQ-010 Port `dp`, output, 1 bit: active-low decimal point.
REQ-011 Port `an`, output, 4 bits: active-low digit enables; an[3] is leftmost.

Function
REQ-012 Latched value regs SHALL capture {S,E,F} on any rising edge with load=1 and otherwise hold.
REQ-013 Refresh counter SHALL count 0..REFRESH_DIV-1, wrap to 0, and never stop after reset release.
REQ-014 Digit index SHALL be a 4-state scan FSM (DIG0→DIG1→DIG2→DIG3→DIG0), advancing only on the cycle the counter wraps.
REQ-015 Digit content SHALL be as follows:
- DIG3: minus (g only, 7'b0111111) if S=1, blank (7'b1111111) if S=0.
- DIG2: decimal E.
- DIG1: tens of F, blank when F<10.
- DIG0: ones of F.
REQ-016 Segment codes SHALL be the standard active-low set: 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001, 5=0010010, 6=0000010, 7=1111000, 8=0000000, 9=0010000.
REQ-017 dp SHALL be 0 only while DIG2 is enabled (separates exponent from significand), else 1.
REQ-018 an SHALL have exactly one bit low after reset: DIG0→1110, DIG1→1101, DIG2→1011, DIG3→0111.
REQ-019 seg, dp and an SHALL be registered outputs computed from the current index and latched value, giving 1 cycle latency.
REQ-020 A load sampled at edge k SHALL appear on seg at edge k+1 if the enabled digit is affected.
REQ-021 load SHALL NOT disturb the refresh counter or the index, including when it coincides with a counter wrap (both the capture and the advance take effect).
REQ-022 Continuous load=1 SHALL track the inputs every cycle with no glitch on an.

Reset
REQ-023 While rst_n=0:
- latched value = 0;
- counter = 0;
- index = DIG0;
- an = 1111;
- seg = 1111111;
- dp = 1.
REQ-024 At the first rising edge after rst_n rises, an SHALL go to 1110 with DIG0 content.
REQ-025 Reset asserted mid-scan SHALL blank the outputs immediately (asynchronously) and restart from DIG0 on release.

Structure
REQ-026 A shared package SHALL hold:
- the segment constants (digits 0-9, SEG_BLANK, SEG_MINUS);
- the digit-index enum;
- the REFRESH_DIV default.
REQ-027 The counter width SHALL be derived from REFRESH_DIV by clog2.
REQ-028 One sub-module, seg7_dec (4-bit value in, 7-bit active-low segments out, combinational), SHALL be instantiated once on the selected digit's value.

Verification (REFRESH_DIV=4)
REQ-029 Reset then release with load never asserted:
- response: an cycles 1110,1101,1011,0111, each for 4 cycles;
- seg = 1000000 on DIG0 and DIG2;
- seg = 1111111 on DIG1 and DIG3;
- dp = 0 only with an = 1011.
REQ-030 Load S=0, E=7, F=15 (from D=2047):
- DIG3 = 1111111;
- DIG2 = 1111000 with dp=0;
- DIG1 = 1111001;
- DIG0 = 0010010.
REQ-031 Load S=1, E=0, F=1 (from D=-1):
- DIG3 = 0111111;
- DIG2 = 1000000;
- DIG1 = 1111111;
- DIG0 = 1111001.
REQ-032 Load pulse coincident with a counter wrap:
- response: the index advances normally;
- the new value appears one edge later;
- the scan period is unchanged.
REQ-033 Assert rst_n=0 mid-DIG2:
- response: an=1111 and seg=1111111 before the next clock edge;
- after release, DIG0 is enabled first and the latched value reads 0.
REQ-034 Change S/E/F while load=0:
- response: seg unchanged over a full 16-cycle scan.
